dmem_arbiter: RTL

- Arbitrates the single-port data memory between two requesters: the CPU load/store path and the program/data loader (test bench or boot loader) port.
- Grants at most one access per cycle and drives the memory's write, read, address and write-data inputs.
- Registers read data back to the winning requester.
- Priority is fixed to the CPU, with a starvation counter that forces a loader slot.

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Purpose : arbitrates one single-port data memory between the CPU load/store
//           path and the program/data loader port; CPU has fixed priority,
//           and a starvation counter forces a loader slot.
// Latency : grant, write commit and memory strobes in the request cycle;
//           read data returned one cycle after the grant edge.
// Backpressure: a requester holds req/we/addr/wdata until its gnt is high;
//           the loader waits at most STARVE_LIMIT cycles.
//
// Ports:
//   clk, rst_n                                  clock, async active-low reset
//   cpu_req/we/addr/wdata -> cpu_gnt            CPU request and grant
//   cpu_rvalid, cpu_rdata                       CPU read response (1-cycle pulse)
//   ldr_req/we/addr/wdata -> ldr_gnt            loader request and grant
//   ldr_rvalid, ldr_rdata                       loader read response
//   mem_write/read/address/write_data           memory drive (all 0 when idle)
//   mem_read_data                               combinational memory read data
module dmem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 8,
  parameter int STARVE_LIMIT = 4   // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // loader port
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  // memory side
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Which requester owns the read data captured at the last edge.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } owner_e;

  owner_e      rsp_owner, rsp_owner_nxt;
  logic [3:0]  starve_cnt, starve_cnt_nxt;
  logic        ldr_win, cpu_win;

  // ---------------------------------------------------------------------------
  // Arbitration. rst_n gates both grants so nothing reaches the memory while
  // reset is asserted, independent of what the requesters are driving.
  // ---------------------------------------------------------------------------
  always_comb begin
    ldr_win = rst_n && ldr_req && (!cpu_req || (starve_cnt == LIMIT));
    cpu_win = rst_n && cpu_req && !ldr_win;
  end

  assign cpu_gnt = cpu_win;
  assign ldr_gnt = ldr_win;

  // ---------------------------------------------------------------------------
  // Memory drive: mux from the winner, all zero with no grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (ldr_win) begin
      mem_write      = ldr_we;
      mem_read       = !ldr_we;
      mem_address    = ldr_addr;
      mem_write_data = ldr_wdata;
    end else if (cpu_win) begin
      mem_write      = cpu_we;
      mem_read       = !cpu_we;
      mem_address    = cpu_addr;
      mem_write_data = cpu_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: counts consecutive cycles the loader asked and lost.
  // Once it reaches LIMIT the loader wins the next request, which clears it,
  // so the saturation guard only matters for robustness.
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!ldr_req || ldr_win) begin
      starve_cnt_nxt = 4'd0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt_nxt = starve_cnt + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Response owner FSM: a read grant this cycle makes its requester the owner
  // of the data captured at this edge; anything else leaves no owner.
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_owner_nxt = OWN_NONE;
    if (ldr_win && !ldr_we) begin
      rsp_owner_nxt = OWN_LDR;
    end else if (cpu_win && !cpu_we) begin
      rsp_owner_nxt = OWN_CPU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_owner  <= OWN_NONE;
      starve_cnt <= 4'd0;
    end else begin
      rsp_owner  <= rsp_owner_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Read data registers: each holds until its own requester's next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata <= '0;
      ldr_rdata <= '0;
    end else begin
      if (rsp_owner_nxt == OWN_CPU) cpu_rdata <= mem_read_data;
      if (rsp_owner_nxt == OWN_LDR) ldr_rdata <= mem_read_data;
    end
  end

  // rvalid is decoded from the registered owner, so a reset mid-response
  // drops the pulse immediately.
  assign cpu_rvalid = (rsp_owner == OWN_CPU);
  assign ldr_rvalid = (rsp_owner == OWN_LDR);

endmodule
